// File: rtl/fb_scanout_pkg.sv
// Shared framebuffer geometry and scanout FSM encoding.
// The GPU clear/draw logic imports the same defaults so both agree on the region.
package fb_scanout_pkg;

   localparam int FB_OFFSET_DEF = 'h100;
   localparam int FB_WIDTH_DEF  = 64;
   localparam int FB_HEIGHT_DEF = 32;
   localparam int ADDR_W        = 12;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_GPU,
      ST_FETCH,
      ST_EMIT
   } state_t;

   function automatic int fb_bytes(input int width, input int height);
      return (width * height) / 8;
   endfunction

endpackage

// File: rtl/fb_scanout_pixel_shifter.sv
// Byte-to-pixel serializer: MSB first, valid/ready output stage, and a strobe
// when the last bit of the loaded byte is taken by the sink.
module fb_scanout_pixel_shifter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] load_data,
   input  logic       pix_ready,
   output logic       pix_valid,
   output logic       pix_data,
   output logic [2:0] bit_idx,
   output logic       last_accept
);

   logic [7:0] shift_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg <= '0;
         bit_idx   <= '0;
         pix_valid <= 1'b0;
      end else if (load) begin
         shift_reg <= load_data;
         bit_idx   <= '0;
         pix_valid <= 1'b1;
      end else if (pix_valid && pix_ready) begin
         if (bit_idx == 3'd7) begin
            pix_valid <= 1'b0;
         end else begin
            shift_reg <= {shift_reg[6:0], 1'b0};
            bit_idx   <= bit_idx + 3'd1;
         end
      end
   end

   assign pix_data    = shift_reg[7];
   assign last_accept = pix_valid && pix_ready && (bit_idx == 3'd7);

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scanout: per frame tick, fetches every framebuffer byte in order
// and streams its pixels with x/y coordinates and line/frame markers.
module fb_scanout
   import fb_scanout_pkg::*;
#(
   parameter int FB_OFFSET = FB_OFFSET_DEF,
   parameter int FB_WIDTH  = FB_WIDTH_DEF,
   parameter int FB_HEIGHT = FB_HEIGHT_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_tick,
   input  logic        gpu_ready,
   output logic        mem_read,
   output logic [11:0] mem_read_addr,
   input  logic [7:0]  mem_read_data,
   input  logic        mem_read_ack,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        pix_data,
   output logic [5:0]  pix_x,
   output logic [4:0]  pix_y,
   output logic        pix_line_end,
   output logic        pix_frame_end,
   output logic        busy,
   output logic        overrun
);

   localparam int FB_BYTES = fb_bytes(FB_WIDTH, FB_HEIGHT);
   localparam int BPR      = FB_WIDTH / 8;
   localparam int BIDX_W   = $clog2(FB_BYTES);
   localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(FB_BYTES - 1);
   localparam logic [11:0]       BASE_ADDR = 12'(FB_OFFSET);

   state_t              state_reg;
   logic [BIDX_W-1:0]   byte_idx_reg;
   logic                pending_reg;
   logic                overrun_reg;
   logic                start;
   logic                load;
   logic                last_accept;
   logic [2:0]          bit_idx;
   logic [BIDX_W-1:0]   col_byte;
   logic [BIDX_W-1:0]   row_idx;

   assign start = frame_tick || pending_reg;
   assign load  = (state_reg == ST_FETCH) && mem_read_ack;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         byte_idx_reg  <= '0;
         pending_reg   <= 1'b0;
         overrun_reg   <= 1'b0;
         mem_read      <= 1'b0;
         mem_read_addr <= BASE_ADDR;
      end else begin
         // Only one tick is remembered; a second one while busy is dropped and flagged.
         if ((state_reg != ST_IDLE) && frame_tick) begin
            if (pending_reg)
               overrun_reg <= 1'b1;
            else
               pending_reg <= 1'b1;
         end

         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  pending_reg <= 1'b0;
                  if (gpu_ready) begin
                     mem_read      <= 1'b1;
                     mem_read_addr <= BASE_ADDR;
                     byte_idx_reg  <= '0;
                     state_reg     <= ST_FETCH;
                  end else begin
                     state_reg <= ST_WAIT_GPU;
                  end
               end
            end
            ST_WAIT_GPU: begin
               if (gpu_ready) begin
                  mem_read      <= 1'b1;
                  mem_read_addr <= BASE_ADDR;
                  byte_idx_reg  <= '0;
                  state_reg     <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (mem_read_ack) begin
                  mem_read  <= 1'b0;
                  state_reg <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (last_accept) begin
                  if (byte_idx_reg == LAST_BYTE) begin
                     state_reg <= ST_IDLE;
                  end else begin
                     byte_idx_reg  <= byte_idx_reg + 1'b1;
                     mem_read      <= 1'b1;
                     mem_read_addr <= mem_read_addr + 12'd1;
                     state_reg     <= ST_FETCH;
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   fb_scanout_pixel_shifter u_shifter (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (load),
      .load_data   (mem_read_data),
      .pix_ready   (pix_ready),
      .pix_valid   (pix_valid),
      .pix_data    (pix_data),
      .bit_idx     (bit_idx),
      .last_accept (last_accept)
   );

   assign col_byte      = byte_idx_reg % BIDX_W'(BPR);
   assign row_idx       = byte_idx_reg / BIDX_W'(BPR);
   assign pix_x         = 6'({col_byte, bit_idx});
   assign pix_y         = 5'(row_idx);
   assign pix_line_end  = pix_valid && (pix_x == 6'(FB_WIDTH - 1));
   assign pix_frame_end = pix_line_end && (pix_y == 5'(FB_HEIGHT - 1));
   assign busy          = (state_reg != ST_IDLE);
   assign overrun       = overrun_reg;

endmodule

// File: tb/tb_fb_scanout.sv
// Self-checking bench for fb_scanout: random framebuffer contents, random memory
// latency and sink backpressure, checked against a per-pixel reference model.
module tb_fb_scanout;

   localparam int BASE   = 'h100;
   localparam int WIDTH  = 64;
   localparam int HEIGHT = 32;
   localparam int NPIX   = WIDTH * HEIGHT;
   localparam int NBYTES = NPIX / 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_tick = 1'b0;
   logic        gpu_ready = 1'b1;
   logic        mem_read;
   logic [11:0] mem_read_addr;
   logic [7:0]  mem_read_data = 8'h00;
   logic        mem_read_ack = 1'b0;
   logic        pix_valid;
   logic        pix_ready = 1'b1;
   logic        pix_data;
   logic [5:0]  pix_x;
   logic [4:0]  pix_y;
   logic        pix_line_end;
   logic        pix_frame_end;
   logic        busy;
   logic        overrun;

   typedef struct {
      int   x;
      int   y;
      logic d;
      logic le;
      logic fe;
   } pix_t;

   pix_t       pix_q[$];
   int         rd_q[$];
   logic [7:0] mem [0:4095];

   int n_vec = 0;
   int n_err = 0;
   int rdy_mode = 1;   // 0 manual, 1 always ready, 2 random
   bit resp_en = 1'b1;
   bit ack_rand = 1'b0;
   int lat_cnt = 0;
   int cur_lat = 0;

   fb_scanout dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .frame_tick    (frame_tick),
      .gpu_ready     (gpu_ready),
      .mem_read      (mem_read),
      .mem_read_addr (mem_read_addr),
      .mem_read_data (mem_read_data),
      .mem_read_ack  (mem_read_ack),
      .pix_valid     (pix_valid),
      .pix_ready     (pix_ready),
      .pix_data      (pix_data),
      .pix_x         (pix_x),
      .pix_y         (pix_y),
      .pix_line_end  (pix_line_end),
      .pix_frame_end (pix_frame_end),
      .busy          (busy),
      .overrun       (overrun)
   );

   always #5 clk = ~clk;

   // Memory responder: acks a held request after cur_lat extra cycles.
   always @(negedge clk) begin
      if (resp_en) begin
         mem_read_ack = 1'b0;
         if (mem_read) begin
            if (lat_cnt >= cur_lat) begin
               mem_read_ack  = 1'b1;
               mem_read_data = mem[int'(mem_read_addr)];
               rd_q.push_back(int'(mem_read_addr));
               lat_cnt = 0;
               cur_lat = ack_rand ? int'($urandom_range(0, 3)) : 0;
            end else begin
               lat_cnt++;
            end
         end
      end
   end

   always @(posedge clk) begin
      if (rdy_mode == 1) begin
         #1 pix_ready = 1'b1;
      end else if (rdy_mode == 2) begin
         #1 pix_ready = ($urandom_range(0, 2) != 0);
      end
   end

   always @(negedge clk) begin
      if (rst_n && pix_valid && pix_ready)
         pix_q.push_back('{int'(pix_x), int'(pix_y), pix_data, pix_line_end, pix_frame_end});
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   task automatic clear_logs();
      pix_q.delete();
      rd_q.delete();
   endtask

   task automatic fill_mem(input bit zero);
      for (int i = 0; i < 4096; i++)
         mem[i] = zero ? 8'h00 : 8'($urandom);
   endtask

   task automatic wait_pix(input int n, input string tag);
      int budget = 30000;
      while (pix_q.size() < n && budget > 0) begin
         step();
         budget--;
      end
      n_vec++;
      if (pix_q.size() < n) begin
         n_err++;
         $display("FAIL %s timeout: got %0d pixels, required %0d", tag, pix_q.size(), n);
      end
   endtask

   // Reference: pixel k of a frame is bit (7 - x%8) of byte BASE + y*W/8 + x/8.
   task automatic check_frame(input string tag, input int pbase, input int rbase);
      int x, y;
      logic [7:0] b;
      logic ed;
      n_vec++;
      if (pix_q.size() < pbase + NPIX || rd_q.size() < rbase + NBYTES) begin
         n_err++;
         $display("FAIL %s size: pixels %0d reads %0d, required %0d/%0d", tag,
                  pix_q.size(), rd_q.size(), pbase + NPIX, rbase + NBYTES);
         return;
      end
      for (int i = 0; i < NBYTES; i++) begin
         n_vec++;
         if (rd_q[rbase + i] !== BASE + i) begin
            n_err++;
            $display("FAIL %s read %0d: addr %h, required %h", tag, i, rd_q[rbase + i], BASE + i);
         end
      end
      for (int k = 0; k < NPIX; k++) begin
         x  = k % WIDTH;
         y  = k / WIDTH;
         b  = mem[BASE + y * (WIDTH / 8) + x / 8];
         ed = b[7 - (x % 8)];
         n_vec++;
         if (pix_q[pbase + k].x !== x || pix_q[pbase + k].y !== y || pix_q[pbase + k].d !== ed ||
             pix_q[pbase + k].le !== (x == WIDTH - 1) || pix_q[pbase + k].fe !== (k == NPIX - 1)) begin
            n_err++;
            $display("FAIL %s pixel %0d: got x%0d y%0d d%0b le%0b fe%0b, required x%0d y%0d d%0b le%0b fe%0b",
                     tag, k, pix_q[pbase + k].x, pix_q[pbase + k].y, pix_q[pbase + k].d,
                     pix_q[pbase + k].le, pix_q[pbase + k].fe, x, y, ed, x == WIDTH - 1, k == NPIX - 1);
         end
      end
      $display("frame %s checked: %0d reads, %0d pixels", tag, NBYTES, NPIX);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) step();
      n_vec++;
      if ({mem_read, pix_valid, busy, overrun, pix_line_end, pix_frame_end, pix_data} !== 7'b0) begin
         n_err++;
         $display("FAIL reset_flags: got %b, required 0000000",
                  {mem_read, pix_valid, busy, overrun, pix_line_end, pix_frame_end, pix_data});
      end
      n_vec++;
      if (mem_read_addr !== 12'h100 || pix_x !== 6'd0 || pix_y !== 5'd0) begin
         n_err++;
         $display("FAIL reset_addr: got addr %h x %0d y %0d, required 100/0/0", mem_read_addr, pix_x, pix_y);
      end
      rst_n = 1'b1;
      step();
      $display("reset: outputs checked");
   endtask

   task automatic test_zero_frame();
      fill_mem(1'b1);
      clear_logs();
      rdy_mode = 1;
      ack_rand = 1'b0;
      pulse_tick();
      n_vec++;
      if (mem_read !== 1'b1 || mem_read_addr !== 12'h100) begin
         n_err++;
         $display("FAIL zero_first_read: got rd %b addr %h, required 1/100", mem_read, mem_read_addr);
      end
      wait_pix(NPIX, "zero");
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL zero_busy_fall: got %b, required 0", busy);
      end
      check_frame("zero", 0, 0);
   endtask

   task automatic test_pattern();
      fill_mem(1'b0);
      mem[BASE]     = 8'h81;
      mem[BASE + 7] = 8'h01;
      clear_logs();
      rdy_mode = 2;
      ack_rand = 1'b1;
      pulse_tick();
      wait_pix(NPIX, "pattern");
      n_vec++;
      if (pix_q.size() > 63 && (pix_q[63].d !== 1'b1 || pix_q[63].le !== 1'b1)) begin
         n_err++;
         $display("FAIL pattern_x63: got d %b le %b, required 1/1", pix_q[63].d, pix_q[63].le);
      end
      check_frame("pattern", 0, 0);
      rdy_mode = 1;
      ack_rand = 1'b0;
      step();
   endtask

   task automatic test_stall();
      int guard = 0;
      logic [7:0] b0;
      fill_mem(1'b0);
      b0 = mem[BASE];
      clear_logs();
      rdy_mode = 0;
      pix_ready = 1'b0;
      pulse_tick();
      while (!pix_valid && guard < 50) begin
         step();
         guard++;
      end
      pix_ready = 1'b1;
      repeat (3) step();
      pix_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_vec++;
         if (pix_valid !== 1'b1 || pix_x !== 6'd3 || pix_y !== 5'd0 || pix_data !== b0[4] || mem_read !== 1'b0) begin
            n_err++;
            $display("FAIL stall_hold %0d: got v%b x%0d y%0d d%b rd%b, required v1 x3 y0 d%b rd0",
                     i, pix_valid, pix_x, pix_y, pix_data, mem_read, b0[4]);
         end
         step();
      end
      pix_ready = 1'b1;
      step();
      n_vec++;
      if (pix_valid !== 1'b1 || pix_x !== 6'd4 || pix_y !== 5'd0) begin
         n_err++;
         $display("FAIL stall_next: got v%b x%0d y%0d, required v1 x4 y0", pix_valid, pix_x, pix_y);
      end
      rdy_mode = 1;
      wait_pix(NPIX, "stall");
      check_frame("stall", 0, 0);
   endtask

   task automatic test_gpu_wait();
      bit seen_rd = 1'b0;
      fill_mem(1'b0);
      clear_logs();
      gpu_ready = 1'b0;
      pulse_tick();
      for (int i = 0; i < 10; i++) begin
         if (mem_read) seen_rd = 1'b1;
         step();
      end
      n_vec++;
      if (seen_rd !== 1'b0 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL gpu_wait_hold: got seen_rd %b busy %b, required 0/1", seen_rd, busy);
      end
      gpu_ready = 1'b1;
      n_vec++;
      if (mem_read !== 1'b0) begin
         n_err++;
         $display("FAIL gpu_wait_early: got rd %b, required 0", mem_read);
      end
      step();
      n_vec++;
      if (mem_read !== 1'b1 || mem_read_addr !== 12'h100) begin
         n_err++;
         $display("FAIL gpu_wait_start: got rd %b addr %h, required 1/100", mem_read, mem_read_addr);
      end
      wait_pix(NPIX, "gpu_wait");
      check_frame("gpu_wait", 0, 0);
   endtask

   task automatic test_tick_at_end();
      int guard = 0;
      fill_mem(1'b0);
      clear_logs();
      rdy_mode = 1;
      pulse_tick();
      while (!pix_frame_end && guard < 30000) begin
         step();
         guard++;
      end
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      n_vec++;
      if (busy !== 1'b0 || mem_read !== 1'b0) begin
         n_err++;
         $display("FAIL end_tick_idle: got busy %b rd %b, required 0/0", busy, mem_read);
      end
      step();
      n_vec++;
      if (mem_read !== 1'b1 || mem_read_addr !== 12'h100) begin
         n_err++;
         $display("FAIL end_tick_restart: got rd %b addr %h, required 1/100", mem_read, mem_read_addr);
      end
      wait_pix(2 * NPIX, "end_tick");
      check_frame("end_tick_a", 0, 0);
      check_frame("end_tick_b", NPIX, NBYTES);
      n_vec++;
      if (overrun !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL end_tick_flags: got overrun %b busy %b, required 0/0", overrun, busy);
      end
   endtask

   task automatic test_back_to_back();
      fill_mem(1'b0);
      clear_logs();
      rdy_mode = 2;
      ack_rand = 1'b1;
      pulse_tick();
      wait_pix(100, "b2b_mid");
      pulse_tick();
      repeat (3) step();
      n_vec++;
      if (overrun !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_one_tick: got overrun %b, required 0", overrun);
      end
      pulse_tick();
      n_vec++;
      if (overrun !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_overrun: got %b, required 1", overrun);
      end
      wait_pix(2 * NPIX, "b2b");
      repeat (200) step();
      n_vec++;
      if (pix_q.size() !== 2 * NPIX || rd_q.size() !== 2 * NBYTES || busy !== 1'b0 || overrun !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_count: got pix %0d rd %0d busy %b ovr %b, required %0d/%0d/0/1",
                  pix_q.size(), rd_q.size(), busy, overrun, 2 * NPIX, 2 * NBYTES);
      end
      check_frame("b2b_a", 0, 0);
      check_frame("b2b_b", NPIX, NBYTES);
      rdy_mode = 1;
      ack_rand = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_fetch();
      bit seen = 1'b0;
      clear_logs();
      resp_en = 1'b0;
      mem_read_ack = 1'b0;
      pulse_tick();
      repeat (2) step();
      n_vec++;
      if (mem_read !== 1'b1 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL rst_pre: got rd %b busy %b, required 1/1", mem_read, busy);
      end
      #1 rst_n = 1'b0;
      #1;
      n_vec++;
      if (mem_read !== 1'b0 || pix_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
         n_err++;
         $display("FAIL rst_async: got rd %b v %b busy %b ovr %b, required 0000",
                  mem_read, pix_valid, busy, overrun);
      end
      step();
      rst_n = 1'b1;
      step();
      mem_read_ack  = 1'b1;
      mem_read_data = 8'hFF;
      step();
      mem_read_ack = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (mem_read || busy || pix_valid) seen = 1'b1;
         step();
      end
      n_vec++;
      if (seen !== 1'b0) begin
         n_err++;
         $display("FAIL rst_late_ack: activity %b, required 0", seen);
      end
      resp_en = 1'b1;
      pulse_tick();
      n_vec++;
      if (mem_read !== 1'b1 || mem_read_addr !== 12'h100) begin
         n_err++;
         $display("FAIL rst_recover: got rd %b addr %h, required 1/100", mem_read, mem_read_addr);
      end
      $display("reset mid-fetch: checked");
   endtask

   initial begin
      test_reset();
      test_zero_frame();
      test_pattern();
      test_stall();
      test_gpu_wait();
      test_tick_at_end();
      test_back_to_back();
      test_reset_mid_fetch();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
- Downstream consumer of the GPU framebuffer. Once per frame tick it reads the 64x32 monochrome framebuffer (256 bytes at 0x100) over a request/ack memory read port.
- Serializes the bytes into a pixel stream with a valid/ready handshake, carrying x/y coordinates and line/frame markers.
- Feeds the display driver.
- Waits for gpu_ready before starting a frame, to avoid tearing at frame start.

Parameters:
- FB_OFFSET, 'h100, byte address of framebuffer byte 0
- FB_WIDTH, 64, pixels per row (multiple of 8)
- FB_HEIGHT, 32, rows per frame

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset; asynchronous, active-low
- frame_tick  input  1  one-cycle pulse requesting a frame scan
- gpu_ready  input  1  high when the GPU is idle (no clear/draw in progress)
- mem_read  output  1  read request, held until acked
- mem_read_addr  output  12  byte address of the request
- mem_read_data  input  8  read data, valid in the ack cycle
- mem_read_ack  input  1  read completion, one cycle
- pix_valid  output  1  pixel stream valid
- pix_ready  input  1  sink accepts the pixel when pix_valid && pix_ready
- pix_data  output  1  pixel value (1 = lit)
- pix_x  output  6  column 0..63
- pix_y  output  5  row 0..31
- pix_line_end  output  1  high with the pixel at x = FB_WIDTH-1
- pix_frame_end  output  1  high with the last pixel of the frame
- busy  output  1  high in any state other than IDLE
- overrun  output  1  sticky; a tick arrived while a tick was already pending

Behaviour:
- Reset (asynchronous, immediate, also mid-frame):
  - All outputs 0; state IDLE.
  - mem_read_addr is FB_OFFSET.
  - Pending flag, byte index, bit index and shift register cleared.
  - An outstanding read is abandoned; a late ack is ignored in IDLE.
- States: IDLE, WAIT_GPU, FETCH, EMIT.
- IDLE:
  - Start condition is frame_tick or pending.
  - If start and gpu_ready: mem_read<=1, mem_read_addr<=FB_OFFSET, byte index<=0, pending<=0, go to FETCH. mem_read is therefore high the cycle after the tick.
  - If start and !gpu_ready: go to WAIT_GPU, pending<=0.
- WAIT_GPU: when gpu_ready is sampled high, issue the first read as above and go to FETCH.
- FETCH:
  - mem_read and mem_read_addr are held stable until mem_read_ack.
  - On ack: shift register<=mem_read_data, mem_read<=0, pix_valid<=1, bit index<=0, go to EMIT.
- EMIT:
  - pix_data is the shift register MSB (MSB = leftmost pixel).
  - pix_x = byte index mod (FB_WIDTH/8) * 8 + bit index.
  - pix_y = byte index / (FB_WIDTH/8).
  - While pix_valid && !pix_ready, all pix_* outputs are held stable.
  - On acceptance of a bit other than bit 7: shift left, advance bit index.
  - On acceptance of bit 7, last byte: pix_valid<=0, go to IDLE.
  - On acceptance of bit 7, otherwise: pix_valid<=0, byte index+1, mem_read<=1 with the next address, go to FETCH.
- Addressing: the address is FB_OFFSET + byte index, truncated to 12 bits. The byte index runs 0..FB_WIDTH*FB_HEIGHT/8-1 (255).
- Markers: pix_line_end and pix_frame_end are combinational from the current pixel coordinates, gated by pix_valid.
- Throughput: one pixel per cycle within a byte, plus one bubble cycle plus memory latency between bytes.
- Frame ticks:
  - A tick while busy sets pending. A tick while pending is already set sets overrun and is discarded.
  - Pending is consumed in IDLE, giving back-to-back frames with no extra tick.
- gpu_ready is checked only at frame start. GPU writes during a scan are visible to later bytes; that is accepted behaviour.
- Simultaneous events: a tick in the same cycle the last pixel is accepted sets pending; the next frame starts from IDLE on the following cycle.

Decomposition:
- Shared header fb_defs.v:
  - Framebuffer offset, length, width, height and bytes-per-row defines.
  - The GPU switches to the same defines, so scanout and clear agree on the region.
- Sub-module fb_pixel_shifter:
  - 8-bit load/shift register with valid/ready output stage and bit counter.
  - Asserts a "last bit accepted" strobe to the FSM.
- Top level holds the FSM, byte counter, pending/overrun flags and memory handshake.

Test Plan:
- Zeroed memory, ack 1 cycle after each request, pix_ready=1, one tick:
  - Exactly 256 reads at addresses 0x100..0x1FF in order.
  - 2048 pixels, all 0.
  - pix_frame_end only at (63,31); busy falls the cycle after.
- mem[0x100]=0x81, mem[0x107]=0x01:
  - Pixels x=0 and x=7 are 1, x=1..6 are 0; x=63,y=0 is 1 with pix_line_end=1.
  - No line_end elsewhere in row 0.
- pix_ready low for 5 cycles at (3,0):
  - pix_data, pix_x and pix_y are stable for all 5 cycles.
  - No new mem_read; pixel (4,0) follows acceptance.
- gpu_ready low at tick, raised 10 cycles later:
  - mem_read stays 0 throughout.
  - mem_read rises the cycle after gpu_ready is sampled high, with addr 0x100.
- Ticks during a frame:
  - Two ticks mid-frame give overrun=1.
  - Exactly one further frame starts after pix_frame_end, with no new tick.
  - overrun stays 1 until rst_n.
- rst_n pulsed low during FETCH:
  - mem_read, pix_valid and busy go to 0 immediately, without waiting for a clock.
  - After release, a late ack is ignored and no reads occur until the next frame_tick.
